compr_packer: RTL and testbench

- Instruction-stream compressor and packer. The opposite direction of compr_fsm, which expands and realigns fetched words.
- Accepts one 32-bit RV64 instruction per handshake. Replaces it with its RVC 16-bit form when it is in the supported subset.
- Packs the resulting halfword stream into little-endian 32-bit memory words. A 32-bit instruction may straddle two words, exactly as compr_fsm expects on fetch.
- Sits between the program loader/trace generator and instruction memory. Used for building and checking compressed images.

---
 rtl/compr_packer.sv | 194 +++++++++++++++++++
 tb/tb_compr_packer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/compr_packer.sv
// compr_packer: instruction-stream compressor and halfword packer.
//
// Accepts one 32-bit RV64 instruction per handshake. When the instruction
// belongs to the supported subset, it is replaced by its 16-bit RVC form.
// The resulting halfword stream is packed into little-endian 32-bit memory
// words. A 32-bit instruction may straddle two words, which matches the
// realignment done on fetch.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_instr is valid
//   in_instr   uncompressed 32-bit instruction
//   in_ready   instruction is accepted when in_valid && in_ready
//   flush      emit the pending half, padded with NOP16
//   flush_done one-cycle pulse: flush handled
//   out_valid  out_word is valid
//   out_word   packed word; bits[15:0] hold the earlier halfword
//   out_ready  consumer accepts out_word
//   cnt_compr  saturating count of compressed instructions
module compr_packer #(
  parameter int          ENABLE_COMPRESS = 1,
  parameter logic [15:0] NOP16           = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic        flush_done,
  output logic        out_valid,
  output logic [31:0] out_word,
  input  logic        out_ready,
  output logic [15:0] cnt_compr
);

  typedef enum logic {EMPTY, HALF} state_t;

  typedef struct packed {
    logic        is16;
    logic [15:0] half;
  } cres_t;

  state_t      state_q, state_d;
  logic [15:0] pend_p0, pend_d;
  logic [31:0] word_p0, word_d;
  logic        vld_p0, vld_d;
  logic        done_p0, done_d;
  logic [15:0] cnt_q, cnt_d;

  cres_t       cres;
  logic        accept;
  logic        do_flush;

  // Maps an instruction onto its RVC form. The first matching rule wins.
  function automatic cres_t compress(input logic [31:0] w);
    cres_t              r;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic               imm6_ok;
    logic               is_addi;
    logic               is_add;
    logic               is_sub;
    logic               is_sd;
    logic               is_jalr;
    r.is16  = 1'b0;
    r.half  = w[15:0];
    opc     = w[6:0];
    f3      = w[14:12];
    f7      = w[31:25];
    rd      = w[11:7];
    rs1     = w[19:15];
    rs2     = w[24:20];
    imm_i   = w[31:20];
    imm_s   = {w[31:25], w[11:7]};
    imm6_ok = (imm_i >= -12'sd32) && (imm_i <= 12'sd31);
    is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
    is_add  = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000);
    is_sub  = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0100000);
    is_sd   = (opc == 7'b0100011) && (f3 == 3'b011);
    is_jalr = (opc == 7'b1100111) && (f3 == 3'b000);
    if (ENABLE_COMPRESS != 0) begin
      if (w == 32'h0000_0013) begin
        r.is16 = 1'b1;
        r.half = 16'h0001;
      end else if (is_addi && rd == rs1 && rd != 5'd0 && imm_i != 12'sd0 && imm6_ok) begin
        r.is16 = 1'b1;
        r.half = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
      end else if (is_addi && rd != 5'd0 && rs1 == 5'd0 && imm6_ok) begin
        r.is16 = 1'b1;
        r.half = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
      end else if (is_add && rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0) begin
        r.is16 = 1'b1;
        r.half = {4'b1000, rd, rs2, 2'b10};
      end else if (is_add && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
        r.is16 = 1'b1;
        r.half = {4'b1001, rd, rs2, 2'b10};
      end else if (is_sub && rd == rs1 && rd[4:3] == 2'b01 && rs2[4:3] == 2'b01) begin
        r.is16 = 1'b1;
        r.half = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
      end else if (is_sd && rs1[4:3] == 2'b01 && rs2[4:3] == 2'b01 &&
                   imm_s >= 12'sd0 && imm_s <= 12'sd248 && imm_s[2:0] == 3'b000) begin
        r.is16 = 1'b1;
        r.half = {3'b111, imm_s[5:3], rs1[2:0], imm_s[7:6], rs2[2:0], 2'b00};
      end else if (is_jalr && rd[4:1] == 4'd0 && rs1 != 5'd0 && imm_i == 12'sd0) begin
        r.is16 = 1'b1;
        r.half = {3'b100, rd[0], rs1, 5'b00000, 2'b10};
      end
    end
    return r;
  endfunction

  assign cres       = compress(in_instr);
  assign in_ready   = !vld_p0 || out_ready;
  assign accept     = in_valid && in_ready;
  // A flush never competes with an instruction: the instruction goes first.
  assign do_flush   = flush && !in_valid && in_ready;

  assign out_valid  = vld_p0;
  assign out_word   = word_p0;
  assign flush_done = done_p0;
  assign cnt_compr  = cnt_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_p0;
    word_d  = word_p0;
    vld_d   = vld_p0 && !out_ready;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    if (accept) begin
      if (cres.is16 && cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
      case (state_q)
        EMPTY: begin
          if (cres.is16) begin
            pend_d  = cres.half;
            state_d = HALF;
          end else begin
            word_d = in_instr;
            vld_d  = 1'b1;
          end
        end
        HALF: begin
          vld_d = 1'b1;
          if (cres.is16) begin
            word_d  = {cres.half, pend_p0};
            state_d = EMPTY;
          end else begin
            // Low half completes the current word, high half stays pending.
            word_d = {in_instr[15:0], pend_p0};
            pend_d = in_instr[31:16];
          end
        end
        default: state_d = EMPTY;
      endcase
    end else if (do_flush) begin
      done_d = 1'b1;
      if (state_q == HALF) begin
        word_d  = {NOP16, pend_p0};
        vld_d   = 1'b1;
        state_d = EMPTY;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      pend_p0 <= 16'h0000;
      word_p0 <= 32'h0000_0000;
      vld_p0  <= 1'b0;
      done_p0 <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pend_p0 <= pend_d;
      word_p0 <= word_d;
      vld_p0  <= vld_d;
      done_p0 <= done_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_compr_packer.sv
// tb_compr_packer: directed bench for compr_packer.
// Drives a linear sequence of hand-computed vectors into a compressing
// instance and a pass-through instance (ENABLE_COMPRESS=0) sharing inputs.
module tb_compr_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        flush_done;
  logic        out_valid;
  logic [31:0] out_word;
  logic        out_ready;
  logic [15:0] cnt_compr;

  logic        in_ready_nc;
  logic        flush_done_nc;
  logic        out_valid_nc;
  logic [31:0] out_word_nc;
  logic [15:0] cnt_compr_nc;

  int vectors;
  int miscompares;

  compr_packer #(.ENABLE_COMPRESS(1), .NOP16(16'h0001)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_word   (out_word),
    .out_ready  (out_ready),
    .cnt_compr  (cnt_compr)
  );

  compr_packer #(.ENABLE_COMPRESS(0), .NOP16(16'h0001)) u_nc (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready_nc),
    .flush      (flush),
    .flush_done (flush_done_nc),
    .out_valid  (out_valid_nc),
    .out_word   (out_word_nc),
    .out_ready  (out_ready),
    .cnt_compr  (cnt_compr_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Presents one instruction and returns #1 after the edge that took it.
  task automatic send(input logic [31:0] w);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_instr = w;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Raises flush and returns #1 after the edge where flush_done appears.
  task automatic do_flush;
    int n;
    n     = 0;
    flush = 1'b1;
    tick();
    while (!flush_done && n < 20) begin
      tick();
      n++;
    end
    flush = 1'b0;
    chk("flush_done", {31'd0, flush_done}, 32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_instr    = 32'h0000_0000;
    flush       = 1'b0;
    out_ready   = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_word", out_word, 32'h0000_0000);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_compr}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_flush_done_nc", {31'd0, flush_done_nc}, 32'd0);

    // Scenario 1: C.ADDI into pending half, LUI straddles, flush pads
    send(32'hFFF0_8093);
    chk("s1_no_output", {31'd0, out_valid}, 32'd0);
    send(32'hB16B_00B7);
    chk("s1_valid", {31'd0, out_valid}, 32'd1);
    chk("s1_word", out_word, 32'h00B7_10FD);
    do_flush();
    chk("s1_flush_valid", {31'd0, out_valid}, 32'd1);
    chk("s1_flush_word", out_word, 32'h0001_B16B);
    chk("s1_cnt", {16'd0, cnt_compr}, 32'd1);
    tick();
    chk("s1_consumed", {31'd0, out_valid}, 32'd0);

    // Scenario 2: C.SUB + C.JALR pack into one word
    do_reset();
    send(32'h40D6_0633);
    chk("s2_no_output", {31'd0, out_valid}, 32'd0);
    send(32'h0004_80E7);
    chk("s2_word", out_word, 32'h9482_8E15);
    chk("s2_cnt", {16'd0, cnt_compr}, 32'd2);
    do_flush();
    chk("s2_empty_flush_no_word", {31'd0, out_valid}, 32'd0);

    // Scenario 3: C.SD, then an sd with misaligned offset stays 32-bit
    send(32'h04B4_B823);
    chk("s3_no_output", {31'd0, out_valid}, 32'd0);
    send(32'h04B4_BA23);
    chk("s3_word", out_word, 32'hBA23_E8AC);
    chk("s3_cnt", {16'd0, cnt_compr}, 32'd3);

    // Scenario 4: backpressure with a new instruction waiting
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s4_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("s4_word_stable", out_word, 32'hBA23_E8AC);
    end
    chk("s4_cnt_frozen", {16'd0, cnt_compr}, 32'd3);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("s4_next_valid", {31'd0, out_valid}, 32'd1);
    chk("s4_next_word", out_word, 32'h5678_04B4);
    do_flush();
    chk("s4_flush_word", out_word, 32'h0001_1234);
    tick();
    chk("s4_no_dup", {31'd0, out_valid}, 32'd0);

    // Scenario 5: reset while HALF and an instruction is offered
    send(32'hFFF0_8093);
    chk("s5_cnt_before", {16'd0, cnt_compr}, 32'd4);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hCAFE_BEEF;
    tick();
    rst = 1'b0;
    chk("s5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("s5_rst_cnt", {16'd0, cnt_compr}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("s5_word_verbatim", out_word, 32'hCAFE_BEEF);
    chk("s5_valid", {31'd0, out_valid}, 32'd1);
    tick();
    do_flush();
    chk("s5_empty_after", {31'd0, out_valid}, 32'd0);

    // Scenario 6: pass-through instance
    do_reset();
    chk("s6_in_ready_nc", {31'd0, in_ready_nc}, 32'd1);
    send(32'hFFF0_8093);
    chk("s6_addi_nc", out_word_nc, 32'hFFF0_8093);
    chk("s6_addi_valid_nc", {31'd0, out_valid_nc}, 32'd1);
    send(32'h40D6_0633);
    chk("s6_sub_nc", out_word_nc, 32'h40D6_0633);
    send(32'h0004_80E7);
    chk("s6_jalr_nc", out_word_nc, 32'h0004_80E7);
    chk("s6_cnt_nc", {16'd0, cnt_compr_nc}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
